// File: rtl/text_console_writer_if.sv
// Character byte stream into the console writer: valid/ready plus colour attributes.
interface text_console_writer_if #(
  parameter int ASCII_WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [ASCII_WIDTH-1:0] in_char;
  logic [3:0]             fg_color;
  logic [3:0]             bg_color;

  modport master (output in_valid, in_char, fg_color, bg_color, input in_ready);
  modport slave  (input in_valid, in_char, fg_color, bg_color, output in_ready);
endinterface

// File: rtl/text_console_writer.sv
// Writer end of the character display buffer: turns a byte stream into cell writes,
// keeping a hardware cursor and handling wrap, LF, CR, BS and screen/row clears.
module text_console_writer #(
  parameter int GRID_ROW    = 5,
  parameter int GRID_COL    = 10,
  parameter int ASCII_WIDTH = 8
) (
  input  logic                        clk_pix,
  input  logic                        rst,
  text_console_writer_if.slave        chars,
  input  logic                        clear_req,
  output logic                        busy,
  output logic [$clog2(GRID_COL)-1:0] cursor_x,
  output logic [$clog2(GRID_ROW)-1:0] cursor_y,
  output logic                        bufferWe,
  output logic [31:0]                 bufferAddr,
  output logic [31:0]                 bufferData
);
  localparam int CW    = $clog2(GRID_COL);
  localparam int RW    = $clog2(GRID_ROW);
  localparam int CELLS = GRID_ROW * GRID_COL;
  localparam int NW    = $clog2(CELLS + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(GRID_COL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(GRID_ROW - 1);
  localparam logic [NW-1:0] ROW_END  = NW'(GRID_COL);
  localparam logic [NW-1:0] ALL_END  = NW'(CELLS);

  typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_ALL} state_t;

  state_t        state, state_d;
  logic [NW-1:0] cnt, cnt_d;
  logic [CW-1:0] col, col_d;
  logic [RW-1:0] row, row_d, next_row;
  logic [3:0]    fg_q, fg_d, bg_q, bg_d;
  logic          we_d;
  logic [31:0]   addr_d, data_d;
  logic [7:0]    ch;
  logic          ready, accept, clear_go;

  function automatic logic [31:0] cell_addr(input logic [RW-1:0] r, input logic [31:0] c);
    return 32'(r) * 32'(GRID_COL) + c;
  endfunction

  function automatic logic [31:0] blank(input logic [3:0] fg, input logic [3:0] bg);
    return {16'h0, bg, fg, 8'h20};
  endfunction

  assign ready          = (state == IDLE) && !clear_req;
  assign chars.in_ready = ready;
  assign busy           = (state != IDLE);
  assign cursor_x       = col;
  assign cursor_y       = row;

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      col        <= '0;
      row        <= '0;
      fg_q       <= '0;
      bg_q       <= '0;
      bufferWe   <= 1'b0;
      bufferAddr <= '0;
      bufferData <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      col        <= col_d;
      row        <= row_d;
      fg_q       <= fg_d;
      bg_q       <= bg_d;
      bufferWe   <= we_d;
      bufferAddr <= addr_d;
      bufferData <= data_d;
    end
  end

  // A clear that starts from IDLE issues its first cell write on the entry edge so the
  // clear writes follow the triggering byte with no gap; the clear states then hold
  // one extra cycle so busy/in_ready cover the cycle that presents the last write.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    col_d    = col;
    row_d    = row;
    fg_d     = fg_q;
    bg_d     = bg_q;
    we_d     = 1'b0;
    addr_d   = bufferAddr;
    data_d   = bufferData;
    clear_go = 1'b0;
    accept   = chars.in_valid && ready;
    ch       = 8'(chars.in_char);
    next_row = (row == ROW_LAST) ? '0 : row + 1'b1;

    case (state)
      IDLE: begin
        if (clear_req) begin
          fg_d     = chars.fg_color;
          bg_d     = chars.bg_color;
          clear_go = 1'b1;
        end else if (accept) begin
          fg_d = chars.fg_color;
          bg_d = chars.bg_color;
          if (ch >= 8'h20 && ch <= 8'h7E) begin
            we_d   = 1'b1;
            addr_d = cell_addr(row, 32'(col));
            data_d = {16'h0, bg_d, fg_d, ch};
            if (col == COL_LAST) begin
              col_d   = '0;
              row_d   = next_row;
              cnt_d   = '0;
              state_d = CLR_ROW;
            end else begin
              col_d = col + 1'b1;
            end
          end else begin
            case (ch)
              8'h0A: begin
                col_d   = '0;
                row_d   = next_row;
                we_d    = 1'b1;
                addr_d  = cell_addr(next_row, 32'd0);
                data_d  = blank(fg_d, bg_d);
                cnt_d   = NW'(1);
                state_d = CLR_ROW;
              end
              8'h0D: col_d = '0;
              8'h08: begin
                if (col != '0) begin
                  col_d  = col - 1'b1;
                  we_d   = 1'b1;
                  addr_d = cell_addr(row, 32'(col - 1'b1));
                  data_d = blank(fg_d, bg_d);
                end
              end
              8'h0C:   clear_go = 1'b1;
              default: ;
            endcase
          end
        end
        if (clear_go) begin
          col_d   = '0;
          row_d   = '0;
          we_d    = 1'b1;
          addr_d  = '0;
          data_d  = blank(fg_d, bg_d);
          cnt_d   = NW'(1);
          state_d = CLR_ALL;
        end
      end
      CLR_ROW: begin
        if (cnt == ROW_END) begin
          state_d = IDLE;
        end else begin
          we_d   = 1'b1;
          addr_d = cell_addr(row, 32'(cnt));
          data_d = blank(fg_q, bg_q);
          cnt_d  = cnt + 1'b1;
        end
      end
      CLR_ALL: begin
        if (cnt == ALL_END) begin
          state_d = IDLE;
        end else begin
          we_d   = 1'b1;
          addr_d = 32'(cnt);
          data_d = blank(fg_q, bg_q);
          cnt_d  = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: directed scenarios plus random traffic
// against a queue-based model of the expected cell writes, cursor and stall time.
module tb_text_console_writer;
  localparam int GR    = 5;
  localparam int GC    = 10;
  localparam int CELLS = GR * GC;

  logic        clk_pix = 1'b0;
  logic        rst;
  logic        clear_req;
  logic        busy;
  logic [3:0]  cursor_x;
  logic [2:0]  cursor_y;
  logic        bufferWe;
  logic [31:0] bufferAddr;
  logic [31:0] bufferData;

  text_console_writer_if #(.ASCII_WIDTH(8)) chars ();

  text_console_writer #(.GRID_ROW(GR), .GRID_COL(GC), .ASCII_WIDTH(8)) dut (
    .clk_pix    (clk_pix),
    .rst        (rst),
    .chars      (chars),
    .clear_req  (clear_req),
    .busy       (busy),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .bufferWe   (bufferWe),
    .bufferAddr (bufferAddr),
    .bufferData (bufferData)
  );

  always #5 clk_pix = ~clk_pix;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          mcol, mrow, mstall;
  logic [3:0]  mfg, mbg;
  logic [63:0] exp_q[$];

  function automatic logic [31:0] blank(input logic [3:0] fg, input logic [3:0] bg);
    return {16'h0, bg, fg, 8'h20};
  endfunction

  task automatic model_reset();
    mcol = 0; mrow = 0; mstall = 0; mfg = '0; mbg = '0;
    exp_q.delete();
  endtask

  task automatic push_write(input int r, input int c, input logic [31:0] d);
    exp_q.push_back({32'(r * GC + c), d});
  endtask

  // Entering a new row clears it; the byte's own write (extra=1) lengthens the stall.
  task automatic model_row_advance(input int extra);
    mrow = (mrow + 1) % GR;
    for (int i = 0; i < GC; i++) push_write(mrow, i, blank(mfg, mbg));
    mstall = GC + extra;
  endtask

  task automatic model_clear(input logic [3:0] fg, input logic [3:0] bg);
    mfg = fg; mbg = bg; mcol = 0; mrow = 0;
    for (int i = 0; i < CELLS; i++) exp_q.push_back({32'(i), blank(fg, bg)});
    mstall = CELLS;
  endtask

  task automatic model_byte(input logic [7:0] c, input logic [3:0] fg, input logic [3:0] bg);
    mfg = fg; mbg = bg;
    if (c >= 8'h20 && c <= 8'h7E) begin
      push_write(mrow, mcol, {16'h0, bg, fg, c});
      if (mcol == GC - 1) begin mcol = 0; model_row_advance(1); end
      else mcol = mcol + 1;
    end else if (c == 8'h0A) begin
      mcol = 0; model_row_advance(0);
    end else if (c == 8'h0D) begin
      mcol = 0;
    end else if (c == 8'h08) begin
      if (mcol > 0) begin mcol = mcol - 1; push_write(mrow, mcol, blank(fg, bg)); end
    end else if (c == 8'h0C) begin
      model_clear(fg, bg);
    end
  endtask

  // One clock: drive inputs, check handshake, clock, then check write port and cursor.
  task automatic cycle(input logic v, input logic [7:0] c, input logic [3:0] fg,
                       input logic [3:0] bg, input logic clr);
    logic        exp_ready, exp_busy, take, clr_take;
    logic [63:0] w;
    chars.in_valid = v; chars.in_char = c; chars.fg_color = fg; chars.bg_color = bg;
    clear_req = clr;
    #1;
    exp_ready = (mstall == 0) && !clr;
    exp_busy  = (mstall > 0);
    n_checks++;
    if (chars.in_ready !== exp_ready) begin
      n_fail++; $display("FAIL in_ready: got %b expected %b (t=%0t)", chars.in_ready, exp_ready, $time);
    end
    n_checks++;
    if (busy !== exp_busy) begin
      n_fail++; $display("FAIL busy: got %b expected %b (t=%0t)", busy, exp_busy, $time);
    end
    take     = v && exp_ready;
    clr_take = clr && (mstall == 0);
    @(posedge clk_pix);
    if (mstall > 0) mstall = mstall - 1;
    if (clr_take) model_clear(fg, bg);
    else if (take) model_byte(c, fg, bg);
    #1;
    n_checks++;
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      if (bufferWe !== 1'b1 || bufferAddr !== w[63:32] || bufferData !== w[31:0]) begin
        n_fail++;
        $display("FAIL write: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h (t=%0t)",
                 bufferWe, bufferAddr, bufferData, w[63:32], w[31:0], $time);
      end
    end else if (bufferWe !== 1'b0) begin
      n_fail++; $display("FAIL no_write: got we=%b addr=%0d expected we=0 (t=%0t)", bufferWe, bufferAddr, $time);
    end
    n_checks++;
    if (cursor_x !== 4'(mcol) || cursor_y !== 3'(mrow)) begin
      n_fail++; $display("FAIL cursor: got (%0d,%0d) expected (%0d,%0d) (t=%0t)",
                         cursor_x, cursor_y, mcol, mrow, $time);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((mstall > 0 || exp_q.size() > 0) && guard < 200) begin
      cycle(1'b0, 8'h00, mfg, mbg, 1'b0);
      guard++;
    end
    cycle(1'b0, 8'h00, mfg, mbg, 1'b0);
  endtask

  task automatic push(input logic [7:0] c, input logic [3:0] fg, input logic [3:0] bg);
    cycle(1'b1, c, fg, bg, 1'b0);
  endtask

  task automatic check_cursor(input string name, input int x, input int y);
    n_checks++;
    if (cursor_x !== 4'(x) || cursor_y !== 3'(y)) begin
      n_fail++; $display("FAIL %s: got (%0d,%0d) expected (%0d,%0d)", name, cursor_x, cursor_y, x, y);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; chars.in_valid = 1'b0; chars.in_char = '0;
    chars.fg_color = '0; chars.bg_color = '0; clear_req = 1'b0;
    @(posedge clk_pix);
    #1;
    n_checks++;
    if (bufferWe !== 1'b0 || bufferAddr !== 32'd0 || bufferData !== 32'd0) begin
      n_fail++; $display("FAIL reset_write_port: got we=%b addr=%h data=%h expected 0/0/0",
                         bufferWe, bufferAddr, bufferData);
    end
    n_checks++;
    if (cursor_x !== 4'd0 || cursor_y !== 3'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: got cursor (%0d,%0d) busy=%b expected (0,0) busy=0",
                         cursor_x, cursor_y, busy);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    cycle(1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    push(8'h41, 4'hF, 4'h0);
    push(8'h42, 4'hF, 4'h0);
    drain();
    check_cursor("cursor_ab", 2, 0);
  endtask

  task automatic test_row_wrap();
    apply_reset();
    for (int i = 0; i < GC; i++) push(8'(8'h61 + i), 4'hF, 4'h0);
    drain();
    check_cursor("cursor_wrap", 0, 1);
  endtask

  task automatic test_line_feed();
    apply_reset();
    for (int i = 0; i < 4; i++) begin push(8'h0A, 4'h3, 4'h1); drain(); end
    for (int i = 0; i < 3; i++) push(8'h30, 4'h3, 4'h1);
    check_cursor("cursor_before_lf", 3, 4);
    push(8'h0A, 4'h5, 4'h6);
    drain();
    check_cursor("cursor_lf_wrap", 0, 0);
  endtask

  task automatic test_backspace();
    apply_reset();
    push(8'h0A, 4'hA, 4'h0); drain();
    push(8'h0A, 4'hA, 4'h0); drain();
    push(8'h08, 4'hA, 4'h0);
    check_cursor("cursor_bs_col0", 0, 2);
    for (int i = 0; i < 4; i++) push(8'h58, 4'hA, 4'h0);
    push(8'h08, 4'hC, 4'h4);
    drain();
    check_cursor("cursor_bs", 3, 2);
  endtask

  task automatic test_clear();
    int bcount = 0;
    apply_reset();
    push(8'h5A, 4'h7, 4'h2);
    cycle(1'b1, 8'h51, 4'h7, 4'h2, 1'b1);
    if (busy) bcount++;
    for (int i = 0; i < CELLS - 1; i++) begin
      cycle(1'b0, 8'h00, 4'h7, 4'h2, 1'b0);
      if (busy) bcount++;
    end
    cycle(1'b0, 8'h00, 4'h7, 4'h2, 1'b0);
    n_checks++;
    if (bcount != CELLS || busy !== 1'b0) begin
      n_fail++; $display("FAIL clear_busy: got %0d busy cycles (busy now %b) expected %0d then 0",
                         bcount, busy, CELLS);
    end
    check_cursor("cursor_clear", 0, 0);
  endtask

  task automatic test_reset_mid_clear();
    apply_reset();
    push(8'h41, 4'h1, 4'h2);
    cycle(1'b0, 8'h00, 4'h1, 4'h2, 1'b1);
    for (int i = 0; i < 18; i++) cycle(1'b0, 8'h00, 4'h1, 4'h2, 1'b0);
    apply_reset();
    cycle(1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
    push(8'h43, 4'h9, 4'h8);
    drain();
  endtask

  task automatic test_random();
    logic [7:0] c;
    logic [3:0] fg, bg;
    logic       v, clr;
    int         r, sel;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      r   = int'($urandom_range(0, 99));
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       c = 8'h0A;
        1:       c = 8'h0D;
        2:       c = 8'h08;
        3:       c = 8'($urandom_range(0, 255));
        default: c = 8'($urandom_range(32, 126));
      endcase
      if (r < 2) c = 8'h0C;
      fg  = 4'($urandom_range(0, 15));
      bg  = 4'($urandom_range(0, 15));
      v   = ($urandom_range(0, 3) != 0);
      clr = (r >= 97);
      if (clr) begin fg = mfg; bg = mbg; end
      cycle(v, c, fg, bg, clr);
    end
    drain();
  endtask

  initial begin
    rst = 1'b1;
    clear_req = 1'b0;
    chars.in_valid = 1'b0;
    chars.in_char = '0;
    chars.fg_color = '0;
    chars.bg_color = '0;
    model_reset();
    @(posedge clk_pix);
    #1;
    test_reset();
    test_back_to_back();
    test_row_wrap();
    test_line_feed();
    test_backspace();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
